sram_ctrl: RTL and testbench

//  Responder side of the MEM-stage memory interface: accepts one 32-bit read/write per

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_wait_counter.sv | 36 +++
 rtl/sram_ctrl.sv | 149 ++++++++++++++
 tb/tb_sram_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage async SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_DQ_W       = 16;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned DEF_WAIT_CYCLES = 5;
  localparam int unsigned DEF_ADDR_BASE   = 1024;
  localparam int unsigned DEF_SRAM_AW     = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Operation latched when a request is accepted.
  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] data;
  } mem_op_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase timer: counts 0..WAIT_CYCLES-1 from a clear, then holds; done marks the last cycle.
module sram_wait_counter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic done
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage responder: one 32-bit access split into two 16-bit async SRAM phases.
// Optional access statistics under `define SRAM_CTRL_STATS_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned ADDR_BASE   = DEF_ADDR_BASE,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [DATA_W-1:0]    address,
  input  logic [DATA_W-1:0]    write_data,
  output logic [DATA_W-1:0]    read_data,
  output logic                 ready,
  inout  wire  [SRAM_DQ_W-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
  output logic [DATA_W-1:0]    rd_count,
  output logic [DATA_W-1:0]    wr_count
);

  localparam int unsigned WORD_W = SRAM_AW - 1;

  state_e              state_q, state_d;
  mem_op_t             op_q, op_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                first_q, first_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [DATA_W-1:0]   addr_off;
  logic                req, in_phase, phase_done, cnt_clear;
  logic [SRAM_DQ_W-1:0] dq_out;

  assign req      = rd_en | wr_en;
  assign addr_off = address - DATA_W'(ADDR_BASE);
  assign in_phase = (state_q == LO) || (state_q == HI);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clear),
    .done (phase_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      word_q    <= '0;
      first_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      word_q    <= word_d;
      first_q   <= first_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next state, request latch, read sampling and phase-timer clear.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    word_d    = word_q;
    first_d   = 1'b0;
    rd_data_d = rd_data_q;
    cnt_clear = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = LO;
          op_d.wr    = wr_en;
          op_d.data  = write_data;
          word_d     = WORD_W'(addr_off >> 2);
          first_d    = 1'b1;
        end
      end
      LO: begin
        cnt_clear = phase_done;
        if (phase_done) begin
          state_d = HI;
          first_d = 1'b1;
          if (!op_q.wr) rd_data_d[15:0] = SRAM_DQ;
        end
      end
      HI: begin
        cnt_clear = 1'b0;
        if (phase_done) begin
          state_d = DONE;
          if (!op_q.wr) rd_data_d[31:16] = SRAM_DQ;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // WE_N stays high on the first and last cycle of a phase for address setup/hold.
  assign dq_out    = (state_q == HI) ? op_q.data[31:16] : op_q.data[15:0];
  assign SRAM_DQ   = (in_phase && op_q.wr) ? dq_out : {SRAM_DQ_W{1'bz}};
  assign SRAM_ADDR = in_phase ? {word_q, (state_q == HI)} : '0;
  assign SRAM_WE_N = ~(in_phase & op_q.wr & ~first_q & ~phase_done);
  assign SRAM_OE_N = ~(in_phase & ~op_q.wr);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign ready     = ~req | (state_q == DONE);
  assign read_data = rd_data_q;

`ifdef SRAM_CTRL_STATS_EN
  logic [DATA_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == DONE) begin
      if (op_q.wr) wr_cnt_d = wr_cnt_q + DATA_W'(1);
      else         rd_cnt_d = rd_cnt_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural 16-bit async SRAM.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] SRAM_DQ;
  wire  [17:0] SRAM_ADDR;
  wire         SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
  wire  [31:0] rd_count, wr_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int oe_low_total = 0;

  logic [15:0] mem [0:63];
  logic        we_tr [0:63];
  logic        oe_tr [0:63];
  logic [17:0] addr_tr [0:63];
  logic [15:0] dq_tr [0:63];

  sram_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: drives DQ while OE_N low, stores on clock edges with WE_N low.
  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[5:0]] : 16'hzzzz;
  always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[5:0]] <= SRAM_DQ;
  always @(negedge clk) if (!SRAM_OE_N) oe_low_total <= oe_low_total + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else pass_cnt++;
  endtask

  task automatic record(input int i);
    we_tr[i]   = SRAM_WE_N;
    oe_tr[i]   = SRAM_OE_N;
    addr_tr[i] = SRAM_ADDR;
    dq_tr[i]   = SRAM_DQ;
  endtask

  task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; write_data = d;
  endtask

  task automatic release_req();
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // Called in cycle 0; lat is the index of the first cycle with ready high.
  task automatic wait_ready(output int lat);
    lat = 0;
    @(negedge clk); record(0);
    while (!ready && lat < 40) begin
      @(negedge clk);
      lat++;
      record(lat);
    end
  endtask

  initial begin
    int lat, lat2, n_lo, n_hi, oe0;
    int exp_wr, exp_rd;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",   32'(ready), 32'd1);
    check("rst_we_n",    32'(SRAM_WE_N), 32'd1);
    check("rst_oe_n",    32'(SRAM_OE_N), 32'd1);
    check("rst_addr",    32'(SRAM_ADDR), 32'd0);
    check("rst_dq_z",    32'(SRAM_DQ === 16'hzzzz), 32'd1);
    check("rst_rdata",   read_data, 32'd0);
    rst = 1'b0;

    // Write then read back at the base address.
    issue(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    wait_ready(lat);
    check("t1_wr_lat", 32'(lat), 32'd11);
    release_req();
    check("t1_mem0", 32'(mem[0]), 32'h0000BEEF);
    check("t1_mem1", 32'(mem[1]), 32'h0000DEAD);
    check("t1_rdata_untouched", read_data, 32'd0);
    issue(1'b0, 1'b1, 32'd1024, 32'h0);
    wait_ready(lat);
    check("t1_rd_lat", 32'(lat), 32'd11);
    check("t1_rdata", read_data, 32'hDEADBEEF);
    check("t1_rd_oe_lo", 32'(oe_tr[3]), 32'd0);
    check("t1_rd_oe_done", 32'(oe_tr[11]), 32'd1);
    release_req();

    // Write at 1028: address sequence and WE_N pulse shape.
    issue(1'b1, 1'b0, 32'd1028, 32'h12345678);
    wait_ready(lat);
    check("t2_lat", 32'(lat), 32'd11);
    check("t2_addr_lo_first", 32'(addr_tr[1]), 32'd2);
    check("t2_addr_lo_last",  32'(addr_tr[5]), 32'd2);
    check("t2_addr_hi_first", 32'(addr_tr[6]), 32'd3);
    check("t2_addr_hi_last",  32'(addr_tr[10]), 32'd3);
    check("t2_we_lo_first", 32'(we_tr[1]), 32'd1);
    check("t2_we_lo_last",  32'(we_tr[5]), 32'd1);
    check("t2_we_hi_first", 32'(we_tr[6]), 32'd1);
    check("t2_we_hi_last",  32'(we_tr[10]), 32'd1);
    n_lo = 0; n_hi = 0;
    for (int i = 1; i <= 5; i++) if (!we_tr[i]) n_lo++;
    for (int i = 6; i <= 10; i++) if (!we_tr[i]) n_hi++;
    check("t2_we_low_lo", 32'(n_lo), 32'd3);
    check("t2_we_low_hi", 32'(n_hi), 32'd3);
    check("t2_dq_lo", 32'(dq_tr[3]), 32'h00005678);
    check("t2_dq_hi", 32'(dq_tr[8]), 32'h00001234);
    check("t2_oe_n", 32'(oe_tr[3]), 32'd1);
    release_req();
    check("t2_mem2", 32'(mem[2]), 32'h00005678);
    check("t2_mem3", 32'(mem[3]), 32'h00001234);

    // Back-to-back reads with rd_en held across the DONE cycle.
    oe0 = oe_low_total;
    issue(1'b0, 1'b1, 32'd1024, 32'h0);
    wait_ready(lat);
    check("t3_lat_a", 32'(lat), 32'd11);
    check("t3_rdata_a", read_data, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 32'd1028, 32'h0);
    wait_ready(lat2);
    check("t3_gap", 32'(lat2), 32'd11);
    check("t3_rdata_b", read_data, 32'h12345678);
    release_req();
    repeat (3) @(posedge clk);
    #1;
    check("t3_oe_cycles", 32'(oe_low_total - oe0), 32'd20);

    // Simultaneous rd_en/wr_en: write wins.
    issue(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A);
    wait_ready(lat);
    check("t4_lat", 32'(lat), 32'd11);
    check("t4_oe_n", 32'(oe_tr[3]), 32'd1);
    release_req();
    check("t4_mem4", 32'(mem[4]), 32'h00005A5A);
    check("t4_mem5", 32'(mem[5]), 32'h0000A5A5);
    check("t4_rdata_kept", read_data, 32'h12345678);

`ifdef SRAM_CTRL_STATS_EN
    exp_wr = 3; exp_rd = 3;
`else
    exp_wr = 0; exp_rd = 0;
`endif
    check("t6_wr_count_pre", wr_count, 32'(exp_wr));
    check("t6_rd_count_pre", rd_count, 32'(exp_rd));

    // Reset in cycle 4 of a write.
    issue(1'b1, 1'b0, 32'd1036, 32'h11112222);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_we_n",  32'(SRAM_WE_N), 32'd1);
    check("t5_dq_z",  32'(SRAM_DQ === 16'hzzzz), 32'd1);
    check("t5_addr",  32'(SRAM_ADDR), 32'd0);
    check("t5_oe_n",  32'(SRAM_OE_N), 32'd1);
    check("t5_partial", 32'(mem[6]), 32'h00002222);
    check("t5_hi_untouched", 32'(mem[7]), 32'd0);
    wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_rdata_rst", read_data, 32'd0);
    check("t5_wr_count_rst", wr_count, 32'd0);
    issue(1'b0, 1'b1, 32'd1024, 32'h0);
    wait_ready(lat);
    check("t5_rd_lat", 32'(lat), 32'd11);
    check("t5_rdata", read_data, 32'hDEADBEEF);
    release_req();

    // Statistics: three writes and one more read after the reset.
    for (int k = 0; k < 3; k++) begin
      issue(1'b1, 1'b0, 32'(1040 + 4 * k), 32'h0BAD_0000 + 32'(k));
      wait_ready(lat);
      release_req();
    end
    issue(1'b0, 1'b1, 32'd1048, 32'h0);
    wait_ready(lat);
    check("t6_rdata", read_data, 32'h0BAD0002);
    release_req();
`ifdef SRAM_CTRL_STATS_EN
    exp_wr = 3; exp_rd = 2;
`else
    exp_wr = 0; exp_rd = 0;
`endif
    check("t6_wr_count", wr_count, 32'(exp_wr));
    check("t6_rd_count", rd_count, 32'(exp_rd));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
